ula_multiciclo: RTL and testbench
=================================

# ula_multiciclo

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and executes the operation on two 32-bit operands. Logic, add/sub, compare and shift codes complete in one cycle. MULT and DIV run as 32-iteration shift-add and restoring-divide sequences. A Start/Busy/Pronto handshake lets the datapath control unit stall the pipeline during iterative operations.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state and outputs.
- Start  in  1  request; sampled only when Busy=0.
- ControleALU  in  4  operation code; encodings are listed in Operation.
- A  in  32  operand 1 and shift source.
- B  in  32  operand 2; B[4:0] is the shift amount.
- Resultado  out  32  registered result (low product word or quotient).
- Hi  out  32  registered high product word or remainder; written only by MULT/DIV.
- Zero  out  1  registered; equals (Resultado == 0), updated with Resultado.
- Busy  out  1  high while an iterative operation is in progress.
- Pronto  out  1  one-cycle pulse when Resultado/Hi are valid.
- Erro  out  1  one-cycle pulse with Pronto for an undefined code or DIV by zero.

## Operation
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 1010 NOR.
  - 0100 SLT; 0101 SGT; 0110 SGET; 0111 SLET. Comparisons are signed; result is 32'd1 or 32'd0.
  - 1011 SLL: A << B[4:0]. 1100 SRL: A >> B[4:0], logical.
  - 1000 MULT: unsigned 64-bit product. Hi = bits [63:32], Resultado = bits [31:0].
  - 1001 DIV: unsigned. Resultado = quotient, Hi = remainder.
- ADD/SUB wrap modulo 2^32; no overflow flag.
- Codes 1101–1111 are undefined: Resultado = 0, Zero = 1, Erro pulses, Hi unchanged.
- DIV with B = 0 takes the single-cycle path: Resultado = 32'hFFFFFFFF, Hi = A, Erro pulses.
- FSM states:
  - OCIOSO: Start with a single-cycle code or DIV-by-zero registers the result, pulses Pronto, and stays in OCIOSO. Start with MULT or DIV (B ≠ 0) latches A, B and the op, clears the counter, and goes to ITER.
  - ITER: one iteration per cycle; 5-bit counter runs 0..31. At count 31, load Resultado/Hi/Zero, pulse Pronto, and go to OCIOSO.
- Operands are latched at acceptance; A/B/ControleALU changes during ITER have no effect.
- Start while Busy=1 is ignored, not queued.

## Timing
- Reset values: Resultado = 0, Hi = 0, Zero = 1, Busy = 0, Pronto = 0, Erro = 0, state = OCIOSO, counter = 0.
- Single-cycle op: Start sampled at edge t0; Resultado and Pronto are valid from t0 for one cycle. Back-to-back Starts are accepted every cycle.
- MULT/DIV: Start accepted at t0. Busy is high from t0 until edge t0+32. Iterations run at edges t0+1..t0+32. Result and Pronto are registered at t0+32. Next Start is accepted at t0+33 at the earliest; Start sampled at t0+32 is ignored.
- Pronto is high exactly one cycle per accepted Start. Resultado/Hi hold their values until the next completion.
- Reset asserted mid-ITER: next edge gives the reset values. No Pronto is generated for the aborted operation.
- Reset and Start in the same cycle: Reset wins; Start is dropped.

## Structure
- Shared package ula_pkg holds:
  - the 4-bit ALU code constants, shared with the ALU control decoder;
  - the FSM state encoding (OCIOSO, ITER);
  - the iteration count constant (32).
- One sub-module, mult_div_iterativo, contains the 64-bit shift-add / restoring-divide datapath and the counter. It exposes start, op, a, b, done, lo and hi.

## Test plan
- ADD A=32'h7FFFFFFF, B=1 -> Resultado 32'h80000000, Zero 0, Pronto at t0, Busy stays 0.
- SLT A=32'hFFFFFFFF (−1), B=0 -> 1. SGT same operands -> 0. SRL A=32'h80000000, B=31 -> 1.
- MULT A=32'hFFFFFFFF, B=2 -> after 32 cycles Hi = 1, Resultado = 32'hFFFFFFFE. Busy high t0..t0+31; a Start pulse in between is ignored.
- DIV A=100, B=7 -> Resultado 14, Hi 2. DIV A=5, B=0 -> at t0 Resultado 32'hFFFFFFFF, Hi 5, Erro = 1.
- Reset at t0+10 of a MULT -> next cycle Busy 0, Pronto 0, Resultado 0, Hi 0. A following ADD 3+4 returns 7.
- Code 1110 -> Resultado 0, Zero 1, Erro and Pronto pulse for one cycle, Hi unchanged.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle execution unit: ALU control codes
// (common with the ALU control decoder), FSM encoding and iteration count.
package ula_pkg;

  // 4-bit ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SGT  = 4'b0101;
  localparam logic [3:0] ALU_SGET = 4'b0110;
  localparam logic [3:0] ALU_SLET = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;

  // Top-level control FSM
  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    ITER   = 1'b1
  } estado_t;

  // Operation selector for the iterative datapath
  typedef enum logic [0:0] {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_t;

  // Number of shift-add / restoring-divide iterations
  localparam int unsigned N_ITER      = 32;
  localparam logic [4:0]  ULTIMA_ITER = 5'(N_ITER - 1);

  // True when the code needs the iterative datapath (DIV by zero does not)
  function automatic logic is_iterativo(input logic [3:0] codigo,
                                        input logic [31:0] divisor);
    return (codigo == ALU_MULT) ||
           ((codigo == ALU_DIV) && (divisor != 32'd0));
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// Start/Busy/Pronto handshake and operand/result bus of the execution unit.
interface ula_multiciclo_if;
  logic        Start;
  logic [3:0]  ControleALU;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Resultado;
  logic [31:0] Hi;
  logic        Zero;
  logic        Busy;
  logic        Pronto;
  logic        Erro;

  // Datapath control unit side
  modport master (
    output Start, ControleALU, A, B,
    input  Resultado, Hi, Zero, Busy, Pronto, Erro
  );

  // Execution unit side
  modport slave (
    input  Start, ControleALU, A, B,
    output Resultado, Hi, Zero, Busy, Pronto, Erro
  );
endinterface

// File: rtl/mult_div_iterativo.sv
// 32-iteration unsigned shift-add multiplier / restoring divider.
// A pair of 32-bit registers holds {hi, lo}: the partial product and the
// multiplier for MULT, the partial remainder and the dividend/quotient for
// DIV. lo/hi present the value produced by the current iteration, so on the
// cycle done is high they are the final product or quotient/remainder.
module mult_div_iterativo
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic        run_q,  run_d;
  logic [4:0]  cnt_q,  cnt_d;
  md_op_t      op_q,   op_d;
  logic [31:0] hi_q,   hi_d;
  logic [31:0] lo_q,   lo_d;
  logic [31:0] opnd_q, opnd_d;

  logic [32:0] soma_s;
  logic [32:0] desloc_s;
  logic [33:0] dif_s;
  logic [31:0] passo_hi_s;
  logic [31:0] passo_lo_s;

  // One iteration step: add-and-shift-right, or shift-left-and-trial-subtract
  always_comb begin
    soma_s     = 33'd0;
    desloc_s   = 33'd0;
    dif_s      = 34'd0;
    passo_hi_s = hi_q;
    passo_lo_s = lo_q;
    if (op_q == OP_DIV) begin
      desloc_s = {hi_q, lo_q[31]};
      dif_s    = {1'b0, desloc_s} - {2'b00, opnd_q};
      if (dif_s[33] == 1'b0) begin
        passo_hi_s = dif_s[31:0];
        passo_lo_s = {lo_q[30:0], 1'b1};
      end else begin
        passo_hi_s = desloc_s[31:0];
        passo_lo_s = {lo_q[30:0], 1'b0};
      end
    end else begin
      soma_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
      passo_hi_s = soma_s[32:1];
      passo_lo_s = {soma_s[0], lo_q[31:1]};
    end
  end

  assign done = run_q && (cnt_q == ULTIMA_ITER);
  assign lo   = passo_lo_s;
  assign hi   = passo_hi_s;

  // Next-state: load operands on start, otherwise iterate while running
  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = 5'd0;
      op_d   = op;
      hi_d   = 32'd0;
      lo_d   = (op == OP_DIV) ? a : b;
      opnd_d = (op == OP_DIV) ? b : a;
    end else if (run_q) begin
      hi_d  = passo_hi_s;
      lo_d  = passo_lo_s;
      cnt_d = cnt_q + 5'd1;
      if (done) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= 5'd0;
      op_q   <= OP_MULT;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      opnd_q <= 32'd0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle execution unit: single-cycle logic/arith/compare/shift codes,
// 32-cycle MULT and DIV through mult_div_iterativo, Start/Busy/Pronto handshake.
module ula_multiciclo
  import ula_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  ula_multiciclo_if.slave  bus
);

  estado_t     estado_q, estado_d;
  logic [31:0] res_q,    res_d;
  logic [31:0] hi_q,     hi_d;
  logic        zero_q,   zero_d;
  logic        busy_q,   busy_d;
  logic        pronto_q, pronto_d;
  logic        erro_q,   erro_d;

  logic [31:0] alu_res_s;
  logic [31:0] alu_hi_s;
  logic        alu_hi_wr_s;
  logic        alu_erro_s;
  logic        alu_iter_s;

  logic        md_start_s;
  md_op_t      md_op_s;
  logic        md_done_s;
  logic [31:0] md_lo_s;
  logic [31:0] md_hi_s;

  // Single-cycle result for the current code (iterative codes flagged only)
  always_comb begin
    alu_res_s   = 32'd0;
    alu_hi_s    = hi_q;
    alu_hi_wr_s = 1'b0;
    alu_erro_s  = 1'b0;
    alu_iter_s  = is_iterativo(bus.ControleALU, bus.B);
    case (bus.ControleALU)
      ALU_AND:  alu_res_s = bus.A & bus.B;
      ALU_OR:   alu_res_s = bus.A | bus.B;
      ALU_ADD:  alu_res_s = bus.A + bus.B;
      ALU_SUB:  alu_res_s = bus.A - bus.B;
      ALU_NOR:  alu_res_s = ~(bus.A | bus.B);
      ALU_SLT:  alu_res_s = {31'd0, $signed(bus.A) <  $signed(bus.B)};
      ALU_SGT:  alu_res_s = {31'd0, $signed(bus.A) >  $signed(bus.B)};
      ALU_SGET: alu_res_s = {31'd0, $signed(bus.A) >= $signed(bus.B)};
      ALU_SLET: alu_res_s = {31'd0, $signed(bus.A) <= $signed(bus.B)};
      ALU_SLL:  alu_res_s = bus.A << bus.B[4:0];
      ALU_SRL:  alu_res_s = bus.A >> bus.B[4:0];
      ALU_MULT: alu_res_s = 32'd0;
      ALU_DIV: begin
        // Only reaches the single-cycle path when the divisor is zero
        alu_res_s   = 32'hFFFF_FFFF;
        alu_hi_s    = bus.A;
        alu_hi_wr_s = 1'b1;
        alu_erro_s  = 1'b1;
      end
      default: begin
        alu_res_s  = 32'd0;
        alu_erro_s = 1'b1;
      end
    endcase
  end

  assign md_op_s = (bus.ControleALU == ALU_DIV) ? OP_DIV : OP_MULT;

  mult_div_iterativo u_mult_div (
    .clk   (Clock),
    .rst   (Reset),
    .start (md_start_s),
    .op    (md_op_s),
    .a     (bus.A),
    .b     (bus.B),
    .done  (md_done_s),
    .lo    (md_lo_s),
    .hi    (md_hi_s)
  );

  // FSM next-state and registered-output update
  always_comb begin
    estado_d   = estado_q;
    res_d      = res_q;
    hi_d       = hi_q;
    zero_d     = zero_q;
    pronto_d   = 1'b0;
    erro_d     = 1'b0;
    md_start_s = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bus.Start) begin
          if (alu_iter_s) begin
            md_start_s = 1'b1;
            estado_d   = ITER;
          end else begin
            res_d    = alu_res_s;
            zero_d   = (alu_res_s == 32'd0);
            hi_d     = alu_hi_wr_s ? alu_hi_s : hi_q;
            pronto_d = 1'b1;
            erro_d   = alu_erro_s;
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      ITER: begin
        if (md_done_s) begin
          res_d    = md_lo_s;
          hi_d     = md_hi_s;
          zero_d   = (md_lo_s == 32'd0);
          pronto_d = 1'b1;
          estado_d = OCIOSO;
        end else begin
          estado_d = ITER;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    busy_d = (estado_d == ITER);
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= OCIOSO;
      res_q    <= 32'd0;
      hi_q     <= 32'd0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
    end
  end

  assign bus.Resultado = res_q;
  assign bus.Hi        = hi_q;
  assign bus.Zero      = zero_q;
  assign bus.Busy      = busy_q;
  assign bus.Pronto    = pronto_q;
  assign bus.Erro      = erro_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_ula_multiciclo;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [31:0] hi_m = 32'd0;

  ula_multiciclo_if bus ();

  ula_multiciclo dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the operation table
  task automatic ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi_in, output logic [31:0] r,
                           output logic [31:0] h, output logic e, output int lat);
    logic [63:0] p;
    h = hi_in; e = 1'b0; lat = 0; r = 32'd0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  r = ($signed(a) >  $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0]; h = p[63:32]; lat = 32;
      end
      4'd9: begin
        if (b == 32'd0) begin
          r = 32'hFFFF_FFFF; h = a; e = 1'b1;
        end else begin
          r = a / b; h = a % b; lat = 32;
        end
      end
      4'd10: r = ~(a | b);
      4'd11: r = a << b[4:0];
      4'd12: r = a >> b[4:0];
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  // Issue one operation and check latency, Busy, results and Pronto width
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] r, h;
    logic e;
    int lat, n;
    ref_model(c, a, b, hi_m, r, h, e, lat);
    bus.Start = 1'b1; bus.ControleALU = c; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.ControleALU = 4'($urandom);
    n = 0;
    while (bus.Pronto !== 1'b1 && n < 40) begin
      check({tag, " busy"}, {31'd0, bus.Busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " res"},  bus.Resultado, r);
    check({tag, " hi"},   bus.Hi, h);
    check({tag, " zero"}, {31'd0, bus.Zero}, {31'd0, (r == 32'd0)});
    check({tag, " erro"}, {31'd0, bus.Erro}, {31'd0, e});
    check({tag, " busy end"}, {31'd0, bus.Busy}, 32'd0);
    hi_m = h;
    @(posedge clk); #1;
    check({tag, " pronto off"}, {31'd0, bus.Pronto}, 32'd0);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.Start = 1'b0; bus.ControleALU = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst res",    bus.Resultado, 32'd0);
    check("rst hi",     bus.Hi, 32'd0);
    check("rst zero",   {31'd0, bus.Zero}, 32'd1);
    check("rst busy",   {31'd0, bus.Busy}, 32'd0);
    check("rst pronto", {31'd0, bus.Pronto}, 32'd0);
    check("rst erro",   {31'd0, bus.Erro}, 32'd0);
    rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, "add ovf");
    run_op(4'b0100, 32'hFFFF_FFFF, 32'd0, "slt");
    run_op(4'b0101, 32'hFFFF_FFFF, 32'd0, "sgt");
    run_op(4'b1100, 32'h8000_0000, 32'd31, "srl");
    run_op(4'b1001, 32'd100, 32'd7, "div");
    run_op(4'b1001, 32'd5, 32'd0, "div0");
    run_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, "undef");

    // Back-to-back single-cycle Starts
    bus.Start = 1'b1; bus.ControleALU = 4'b0000; bus.A = 32'hF0F0_F0F0; bus.B = 32'hFF00_FF00;
    @(posedge clk); #1;
    check("b2b and", bus.Resultado, 32'hF000_F000);
    check("b2b p1",  {31'd0, bus.Pronto}, 32'd1);
    bus.ControleALU = 4'b1011; bus.A = 32'd3; bus.B = 32'd4;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    check("b2b sll", bus.Resultado, 32'd48);
    check("b2b p2",  {31'd0, bus.Pronto}, 32'd1);
    @(posedge clk); #1;
    check("b2b p off", {31'd0, bus.Pronto}, 32'd0);

    // MULT with Starts during Busy and at the completion edge, all ignored
    bus.Start = 1'b1; bus.ControleALU = 4'b1000; bus.A = 32'hFFFF_FFFF; bus.B = 32'd2;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      check("mult busy", {31'd0, bus.Busy}, 32'd1);
      check("mult no pronto", {31'd0, bus.Pronto}, 32'd0);
      bus.Start = (i == 5) ? 1'b1 : 1'b0;
      bus.ControleALU = 4'b0010; bus.A = 32'd1; bus.B = 32'd1;
      @(posedge clk); #1;
    end
    check("mult busy31", {31'd0, bus.Busy}, 32'd1);
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    check("mult pronto", {31'd0, bus.Pronto}, 32'd1);
    check("mult lo", bus.Resultado, 32'hFFFF_FFFE);
    check("mult hi", bus.Hi, 32'd1);
    check("mult busy off", {31'd0, bus.Busy}, 32'd0);
    @(posedge clk); #1;
    check("late start ignored", {31'd0, bus.Pronto}, 32'd0);
    check("mult hold", bus.Resultado, 32'hFFFF_FFFE);
    hi_m = 32'd1;

    // Reset in the middle of a MULT
    bus.Start = 1'b1; bus.ControleALU = 4'b1000; bus.A = 32'hDEAD_BEEF; bus.B = 32'h1234_5678;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy",   {31'd0, bus.Busy}, 32'd0);
    check("abort pronto", {31'd0, bus.Pronto}, 32'd0);
    check("abort res",    bus.Resultado, 32'd0);
    check("abort hi",     bus.Hi, 32'd0);
    hi_m = 32'd0;
    repeat (25) begin
      @(posedge clk); #1;
      check("abort quiet", {31'd0, bus.Pronto}, 32'd0);
    end
    run_op(4'b0010, 32'd3, 32'd4, "add after rst");

    // Reset and Start together: Start dropped
    rst = 1'b1; bus.Start = 1'b1; bus.ControleALU = 4'b0010; bus.A = 32'd9; bus.B = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; bus.Start = 1'b0;
    check("rst+start pronto", {31'd0, bus.Pronto}, 32'd0);
    check("rst+start res", bus.Resultado, 32'd0);
    hi_m = 32'd0;

    // Random operations
    for (int k = 0; k < 40; k++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'h0000_00FF;
      run_op(c, a, b, $sformatf("rand%0d op%0d", k, c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
